// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared opcodes, instruction field positions and retirement FSM encoding
package rob_commit_pkg;
   localparam logic [4:0] OP_J   = 5'd1;
   localparam logic [4:0] OP_BNE = 5'd2;
   localparam logic [4:0] OP_BLT = 5'd5;
   localparam logic [4:0] OP_SW  = 5'b00111;
   localparam logic [31:0] BR_MASK_DEFAULT = (32'd1 << OP_J) | (32'd1 << OP_BNE)
                                           | (32'd1 << OP_BLT) | (32'd1 << OP_SW);
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 22;
   typedef enum logic {RUN = 1'b0, STORE = 1'b1} state_t;
endpackage

// File: rtl/rob_commit_decode.sv
// commit_decode: classifies the ROB head instruction for retirement
module commit_decode
   import rob_commit_pkg::*;
#(
   parameter logic [4:0]  OPCODE_SW      = OP_SW,
   parameter logic [31:0] OPCODE_BR_MASK = BR_MASK_DEFAULT
) (
   input  logic [OPC_HI:RD_LO] instr,
   output logic                is_store,
   output logic                writes_rd,
   output logic [4:0]          rd
);
   logic [4:0] opc;
   assign opc       = instr[OPC_HI:OPC_LO];
   assign rd        = instr[RD_HI:RD_LO];
   assign is_store  = opc == OPCODE_SW;
   assign writes_rd = !OPCODE_BR_MASK[opc] && rd != 5'd0;
endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement of the ROB head into the register file or data memory
module rob_commit
   import rob_commit_pkg::*;
#(
   parameter logic [4:0]  OPCODE_SW      = OP_SW,
   parameter logic [31:0] OPCODE_BR_MASK = BR_MASK_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rob_empty,
   input  logic [31:0] rob_head_instr,
   input  logic [31:0] rob_head_val,
   input  logic        rob_head_ready,
   output logic        rob_pop,
   input  logic        stall,
   output logic        rf_wEn,
   output logic [4:0]  rf_wAddr,
   output logic [31:0] rf_wData,
   output logic [4:0]  rf_rAddr,
   input  logic [31:0] rf_rData,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   input  logic        mem_ack,
   output logic [31:0] commit_count,
   output logic        busy
);
   state_t      state, state_n;
   logic        is_store, writes_rd, head_ok;
   logic [4:0]  rd;
   logic [31:0] count_q;
   commit_decode #(.OPCODE_SW(OPCODE_SW), .OPCODE_BR_MASK(OPCODE_BR_MASK)) u_dec (
      .instr     (rob_head_instr[OPC_HI:RD_LO]),
      .is_store  (is_store),
      .writes_rd (writes_rd),
      .rd        (rd)
   );
   assign head_ok      = !rob_empty && rob_head_ready && rob_head_instr != 32'd0;
   assign rf_wAddr     = rd;
   assign rf_wData     = rob_head_val;
   assign rf_rAddr     = rd;
   assign mem_addr     = rob_head_val;
   assign mem_data     = rf_rData;
   assign commit_count = count_q;
   assign busy         = state == STORE;
   // strobes and next state; an entered store ignores stall and waits only for mem_ack
   always_comb begin
      state_n = state;
      rob_pop = 1'b0;
      rf_wEn  = 1'b0;
      mem_req = 1'b0;
      if (!reset) begin
         if (state == STORE) begin
            mem_req = 1'b1;
            rob_pop = mem_ack;
            state_n = mem_ack ? RUN : STORE;
         end else if (head_ok && !stall) begin
            rob_pop = !is_store;
            rf_wEn  = !is_store && writes_rd;
            state_n = is_store ? STORE : RUN;
         end
      end
   end
   // state register
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= RUN;
      else       state <= state_n;
   // retired-instruction counter, wraps naturally
   always_ff @(posedge clock or posedge reset)
      if (reset)        count_q <= 32'd0;
      else if (rob_pop) count_q <= count_q + 32'd1;
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed stimulus with scoreboard-checked retirement events
module tb_rob_commit;
   typedef struct packed {
      logic        pop;
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        req;
      logic [31:0] ma;
      logic [31:0] md;
   } ev_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rob_empty = 1'b1;
   logic [31:0] rob_head_instr = 32'd0;
   logic [31:0] rob_head_val = 32'd0;
   logic        rob_head_ready = 1'b0;
   logic        stall = 1'b0;
   logic        mem_ack = 1'b0;
   logic        rob_pop, rf_wEn, mem_req, busy;
   logic [4:0]  rf_wAddr, rf_rAddr;
   logic [31:0] rf_wData, rf_rData, mem_addr, mem_data, commit_count;
   int          pass_n = 0;
   int          total_n = 0;
   ev_t         exp_q[$];

   always #5 clock = ~clock;

   assign rf_rData = (rf_rAddr == 5'd7) ? 32'h0000_DEAD : {27'h5A5A000, rf_rAddr};

   rob_commit dut (
      .clock(clock), .reset(reset), .rob_empty(rob_empty), .rob_head_instr(rob_head_instr),
      .rob_head_val(rob_head_val), .rob_head_ready(rob_head_ready), .rob_pop(rob_pop),
      .stall(stall), .rf_wEn(rf_wEn), .rf_wAddr(rf_wAddr), .rf_wData(rf_wData),
      .rf_rAddr(rf_rAddr), .rf_rData(rf_rData), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_ack(mem_ack), .commit_count(commit_count), .busy(busy)
   );

   function automatic ev_t mk_ev(input logic pop, wen, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic req, input logic [31:0] ma, md);
      return '{pop, wen, wen ? wa : 5'd0, wen ? wd : 32'd0, req, req ? ma : 32'd0, req ? md : 32'd0};
   endfunction

   function automatic logic [31:0] ins(input logic [4:0] opc, rd);
      return {opc, rd, 22'h00001};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, exp);
      total_n++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else pass_n++;
   endtask

   task automatic cyc(input logic e, r, input logic [31:0] i, v, input logic s, a);
      @(posedge clock);
      #1;
      rob_empty = e; rob_head_ready = r; rob_head_instr = i; rob_head_val = v; stall = s; mem_ack = a;
   endtask

   task automatic expect_ev(input logic pop, wen, input logic [4:0] wa, input logic [31:0] wd,
                            input logic req, input logic [31:0] ma, md);
      exp_q.push_back(mk_ev(pop, wen, wa, wd, req, ma, md));
   endtask

   // monitor: every cycle with an active strobe must match the next expected event
   always @(negedge clock) begin
      ev_t a, e;
      if (!reset && (rob_pop || rf_wEn || mem_req)) begin
         a = mk_ev(rob_pop, rf_wEn, rf_wAddr, rf_wData, mem_req, mem_addr, mem_data);
         total_n++;
         if (exp_q.size() == 0) $display("FAIL unexpected_event: got %h expected none", a);
         else begin
            e = exp_q.pop_front();
            if (a !== e) $display("FAIL event: got %h expected %h", a, e);
            else pass_n++;
         end
      end
   end

   initial begin
      repeat (10) begin
         @(negedge clock);
         chk("reset_strobes", {61'd0, rob_pop, rf_wEn, mem_req}, 64'd0);
         chk("reset_count", commit_count, 64'd0);
      end
      chk("reset_busy", busy, 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      cyc(0, 1, ins(5'd0, 5'd3), 32'h11, 0, 0); expect_ev(1, 1, 5'd3, 32'h11, 0, 0, 0);
      cyc(0, 1, ins(5'd0, 5'd4), 32'h22, 0, 0); expect_ev(1, 1, 5'd4, 32'h22, 0, 0, 0);
      cyc(0, 1, ins(5'd0, 5'd5), 32'h33, 0, 0); expect_ev(1, 1, 5'd5, 32'h33, 0, 0, 0);
      cyc(1, 0, 32'd0, 32'd0, 0, 0);
      chk("alu_count", commit_count, 64'd3);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h100, 0, 0);
      chk("store_detect_idle", busy, 64'd0);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h100, 0, 0); expect_ev(0, 0, 0, 0, 1, 32'h100, 32'hDEAD);
      chk("store_busy", busy, 64'd1);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h100, 0, 0); expect_ev(0, 0, 0, 0, 1, 32'h100, 32'hDEAD);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h100, 0, 1); expect_ev(1, 0, 0, 0, 1, 32'h100, 32'hDEAD);
      cyc(1, 0, 32'd0, 32'd0, 0, 0);
      chk("store_count", commit_count, 64'd4);
      chk("store_done_busy", busy, 64'd0);
      cyc(0, 1, ins(5'd0, 5'd0), 32'h55, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, ins(5'd2, 5'd5), 32'h66, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, ins(5'd0, 5'd6), 32'h77, 0, 0);
      cyc(0, 0, ins(5'd0, 5'd6), 32'h77, 0, 0);
      cyc(0, 1, ins(5'd0, 5'd6), 32'h77, 0, 0); expect_ev(1, 1, 5'd6, 32'h77, 0, 0, 0);
      cyc(1, 0, 32'd0, 32'd0, 0, 0);
      chk("misc_count", commit_count, 64'd7);
      cyc(0, 1, ins(5'd0, 5'd8), 32'h88, 1, 0);
      cyc(0, 1, ins(5'd0, 5'd8), 32'h88, 1, 0);
      chk("stall_count", commit_count, 64'd7);
      cyc(0, 1, ins(5'd0, 5'd8), 32'h88, 0, 0); expect_ev(1, 1, 5'd8, 32'h88, 0, 0, 0);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h200, 0, 0);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h200, 1, 0); expect_ev(0, 0, 0, 0, 1, 32'h200, 32'hDEAD);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h200, 1, 1); expect_ev(1, 0, 0, 0, 1, 32'h200, 32'hDEAD);
      cyc(1, 0, 32'd0, 32'd0, 0, 0);
      chk("stall_store_count", commit_count, 64'd9);
      cyc(1, 0, 32'd0, 32'd0, 0, 1);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h300, 1, 1);
      cyc(1, 0, 32'd0, 32'd0, 0, 0);
      chk("ack_outside_busy", busy, 64'd0);
      chk("ack_outside_count", commit_count, 64'd9);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h400, 0, 0);
      cyc(0, 1, ins(5'b00111, 5'd7), 32'h400, 0, 0); expect_ev(0, 0, 0, 0, 1, 32'h400, 32'hDEAD);
      @(posedge clock);
      #1 chk("pre_reset_req", mem_req, 64'd1);
      #1 reset = 1'b1; rob_empty = 1'b1; rob_head_ready = 1'b0; rob_head_instr = 32'd0;
      #1 chk("reset_mid_store_req", {62'd0, mem_req, rob_pop}, 64'd0);
      chk("reset_mid_store_busy", busy, 64'd0);
      chk("reset_mid_store_count", commit_count, 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      force dut.count_q = 32'hFFFF_FFFF;
      #1 chk("preload", commit_count, 64'hFFFF_FFFF);
      release dut.count_q;
      cyc(0, 1, ins(5'd0, 5'd9), 32'h99, 0, 0); expect_ev(1, 1, 5'd9, 32'h99, 0, 0, 0);
      cyc(1, 0, 32'd0, 32'd0, 0, 0);
      chk("wrap_count", commit_count, 64'd0);
      repeat (2) @(posedge clock);
      chk("scoreboard_drained", exp_q.size(), 64'd0);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
